// File: rtl/adder_bist_checker.sv
// Built-in self test for full / ripple-carry adders: sweeps {Cprev,X,Y}.
// Define ADDER_BIST_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module adder_bist_checker #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  output logic [WIDTH-1:0]   X,
  output logic [WIDTH-1:0]   Y,
  output logic               Cprev,
  input  logic [WIDTH-1:0]   RES,
  input  logic               Cnext,
  output logic               BUSY,
  output logic               DONE,
  output logic               PASS,
  output logic [15:0]        ERR_CNT,
  output logic [2*WIDTH:0]   FAIL_VEC
);

  localparam int VW = 2 * WIDTH + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [VW-1:0] VLAST = '1;
  localparam logic [CW-1:0] CLAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state, state_n;
  logic [VW-1:0] v, v_n, fail_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   err_n;
  logic          busy_n, done_n;
  logic [WIDTH:0] sum;
  logic          miss, stop;

  assign {Cprev, X, Y} = v;
  assign sum  = {1'b0, X} + {1'b0, Y} + {{WIDTH{1'b0}}, Cprev};
  assign miss = ({Cnext, RES} != sum);
  assign PASS = DONE && (ERR_CNT == 16'd0);

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  assign stop = miss;
`else
  assign stop = 1'b0;
`endif

  always_comb begin
    state_n = state;
    v_n     = v;
    cnt_n   = cnt;
    err_n   = ERR_CNT;
    fail_n  = FAIL_VEC;
    busy_n  = BUSY;
    done_n  = DONE;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_n = S_APPLY;
          v_n     = '0;
          cnt_n   = '0;
          err_n   = '0;
          fail_n  = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
        end
      end
      S_APPLY: begin
        if (cnt == CLAST) state_n = S_CHECK;
        else              cnt_n   = cnt + 1'b1;
      end
      S_CHECK: begin
        if (miss) begin
          if (ERR_CNT != 16'hFFFF) err_n = ERR_CNT + 16'd1;
          // an empty count means this is the first failure of the sweep
          if (ERR_CNT == 16'd0) fail_n = v;
        end
        if (v == VLAST || stop) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n = S_APPLY;
          v_n     = v + 1'b1;
          cnt_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      v        <= '0;
      cnt      <= '0;
      ERR_CNT  <= '0;
      FAIL_VEC <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_n;
      v        <= v_n;
      cnt      <= cnt_n;
      ERR_CNT  <= err_n;
      FAIL_VEC <= fail_n;
      BUSY     <= busy_n;
      DONE     <= done_n;
    end
  end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Bench: two checker instances (1-bit/SETTLE 2, 2-bit/SETTLE 1) each
// driving a behavioural adder with selectable faults.
module tb_adder_bist_checker;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic st [2];

  logic       x0, y0, c0, res0, cn0;
  logic       busy0, done0, pass0;
  logic [15:0] err0;
  logic [2:0] fv0;

  logic [1:0] x1, y1, res1;
  logic       c1, cn1;
  logic       busy1, done1, pass1;
  logic [15:0] err1;
  logic [4:0] fv1;

  int mode [2];
  int mask [2][32];
  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  adder_bist_checker #(.WIDTH(1), .SETTLE(2)) dut0 (
    .CLK(CLK), .RST(RST), .START(st[0]),
    .X(x0), .Y(y0), .Cprev(c0), .RES(res0), .Cnext(cn0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0),
    .ERR_CNT(err0), .FAIL_VEC(fv0)
  );

  adder_bist_checker #(.WIDTH(2), .SETTLE(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(st[1]),
    .X(x1), .Y(y1), .Cprev(c1), .RES(res1), .Cnext(cn1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1),
    .ERR_CNT(err1), .FAIL_VEC(fv1)
  );

  // adder under test: true sum, optionally corrupted
  function automatic int resp(int d, int m, int vec, int mk);
    int w, c, x, y, s;
    w = d ? 2 : 1;
    y = vec & ((1 << w) - 1);
    x = (vec >> w) & ((1 << w) - 1);
    c = (vec >> (2 * w)) & 1;
    s = x + y + c;
    case (m)
      1: s = s & (1 << w);
      2: s = s ^ (1 << w);
      3: s = s ^ mk;
      default: ;
    endcase
    return s;
  endfunction

  always_comb begin
    {cn0, res0} = 2'(resp(0, mode[0], int'({c0, x0, y0}),
                          mask[0][{c0, x0, y0}]));
    {cn1, res1} = 3'(resp(1, mode[1], int'({c1, x1, y1}),
                          mask[1][{c1, x1, y1}]));
  end

  logic [4:0]  vec_o  [2];
  logic        busy_o [2];
  logic        done_o [2];
  logic        pass_o [2];
  logic [15:0] err_o  [2];
  logic [4:0]  fv_o   [2];

  always_comb begin
    vec_o[0]  = {2'b00, c0, x0, y0};
    vec_o[1]  = {c1, x1, y1};
    busy_o[0] = busy0;
    busy_o[1] = busy1;
    done_o[0] = done0;
    done_o[1] = done1;
    pass_o[0] = pass0;
    pass_o[1] = pass1;
    err_o[0]  = err0;
    err_o[1]  = err1;
    fv_o[0]   = {2'b00, fv0};
    fv_o[1]   = fv1;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // expected mismatch count and first failing vector over a whole sweep
  task automatic ref_run(input int d, input int m,
                         output int cnt, output int first);
    int nv, w, s;
    nv = d ? 32 : 8;
    w = d ? 2 : 1;
    cnt = 0;
    first = -1;
    for (int v = 0; v < nv; v++) begin
      s = ((v >> (2 * w)) & 1) + ((v >> w) & ((1 << w) - 1))
        + (v & ((1 << w) - 1));
      if (resp(d, m, v, mask[d][v]) != s) begin
        cnt++;
        if (first < 0) first = v;
      end
    end
  endtask

  task automatic sweep(input int d, input int m, input bit mid);
    int per, nv, ecnt, efirst, exp_err, exp_cyc, exp_last;
    int k, bad, lim;
    per = d ? 2 : 3;
    nv = d ? 32 : 8;
    mode[d] = m;
    if (m == 3)
      for (int v = 0; v < 32; v++)
        mask[d][v] = ($urandom % 4 == 0) ?
                     int'($urandom_range(1, d ? 7 : 3)) : 0;
    ref_run(d, m, ecnt, efirst);
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    exp_err  = (ecnt > 0) ? 1 : 0;
    exp_cyc  = (ecnt > 0) ? (efirst + 1) * per : nv * per;
    exp_last = (ecnt > 0) ? efirst : nv - 1;
`else
    exp_err  = ecnt;
    exp_cyc  = nv * per;
    exp_last = nv - 1;
`endif
    @(negedge CLK);
    st[d] = 1'b1;
    @(posedge CLK);
    #1;
    st[d] = 1'b0;
    chk("busy_start", 32'(busy_o[d]), 1);
    k = 0;
    bad = 0;
    lim = 2 * nv * per + 10;
    while (!done_o[d] && k < lim) begin
      if (int'(vec_o[d]) != k / per) bad++;
      if (mid && k == 2 * per + 1) st[d] = 1'b1;
      @(posedge CLK);
      #1;
      st[d] = 1'b0;
      k++;
    end
    chk("vec_order", bad, 0);
    chk("done_cycles", k, exp_cyc);
    chk("done", 32'(done_o[d]), 1);
    chk("busy_end", 32'(busy_o[d]), 0);
    chk("err_cnt", 32'(err_o[d]), exp_err);
    chk("fail_vec", 32'(fv_o[d]), (ecnt > 0) ? efirst : 0);
    chk("pass", 32'(pass_o[d]), (exp_err == 0) ? 1 : 0);
    chk("last_vec", 32'(vec_o[d]), exp_last);
    repeat (2) @(posedge CLK);
    #1;
    chk("done_hold", 32'(done_o[d]), 1);
  endtask

  initial begin
    int n;
    st[0] = 1'b0;
    st[1] = 1'b0;
    mode[0] = 0;
    mode[1] = 0;
    for (int v = 0; v < 32; v++) begin
      mask[0][v] = 0;
      mask[1][v] = 0;
    end
    repeat (3) @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++)
      chk("reset_outs", {vec_o[d], busy_o[d], done_o[d], pass_o[d],
                         err_o[d], fv_o[d]}, 0);
    @(negedge CLK);
    RST = 1'b0;

    sweep(0, 0, 0);
    sweep(0, 1, 0);
    sweep(0, 2, 0);
    sweep(1, 0, 0);
    sweep(1, 1, 0);

    // abort at V=3
    @(negedge CLK);
    st[0] = 1'b1;
    @(posedge CLK);
    #1;
    st[0] = 1'b0;
    n = 0;
    while (vec_o[0] != 5'd3 && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("abort_reach", 32'(vec_o[0]), 3);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_outs", {vec_o[0], busy_o[0], done_o[0], pass_o[0],
                       err_o[0], fv_o[0]}, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("abort_idle", {busy_o[0], done_o[0]}, 0);

    sweep(0, 0, 0);
    sweep(0, 0, 1);
    sweep(1, 0, 1);

    repeat (8) sweep(int'($urandom % 2), 3, 1'($urandom % 2));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
